// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between CPU (write/read/fetch) and DMA with starvation guard
module mem_arbiter #(
    parameter int RV     = 32,
    parameter int VA     = RV,
    parameter int STARVE = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifetch,
    input  logic [1:0]            rstrobe,
    input  logic [RV/8-1:0]       wmask,
    input  logic [VA-RV/16-1:0]   addr,
    input  logic [RV-1:0]         wdata,
    input  logic                  io_access,
    output logic                  idone,
    output logic                  rdone,
    output logic                  wdone,
    output logic [RV-1:0]         rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [VA-RV/16-1:0]   dma_addr,
    input  logic [RV-1:0]         dma_wdata,
    output logic                  dma_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_io,
    output logic [VA-RV/16-1:0]   mem_addr,
    output logic [RV-1:0]         mem_wdata,
    output logic [RV/8-1:0]       mem_wmask,
    output logic [1:0]            mem_rstrobe,
    input  logic                  mem_ack,
    input  logic [RV-1:0]         mem_rdata
);

    localparam int AW = VA - RV / 16;
    localparam int MW = RV / 8;
    localparam logic [3:0] STARVE_W = 4'(STARVE);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_WR, OWN_RD, OWN_IF, OWN_DMA} owner_t;

    state_t          state_q;
    owner_t          owner_q;
    owner_t          owner_d;
    logic [3:0]      starve_q;
    logic [3:0]      starve_d;
    logic            mem_req_q;
    logic            mem_we_q;
    logic            mem_io_q;
    logic [AW-1:0]   mem_addr_q;
    logic [RV-1:0]   mem_wdata_q;
    logic [MW-1:0]   mem_wmask_q;
    logic [1:0]      mem_rstrobe_q;
    logic [RV-1:0]   rdata_q;
    logic            idone_q;
    logic            rdone_q;
    logic            wdone_q;
    logic            dma_done_q;

    logic            cpu_wr;
    logic            cpu_rd;
    logic            cpu_any;
    logic            grant_any;
    logic            we_d;
    logic            io_d;
    logic [AW-1:0]   addr_d;
    logic [RV-1:0]   wdata_d;
    logic [MW-1:0]   wmask_d;
    logic [1:0]      rstrobe_d;

    // Priority pick of the next owner and its command, plus the starvation count it implies
    always_comb begin
        cpu_wr    = |wmask;
        cpu_rd    = |rstrobe;
        cpu_any   = cpu_wr || cpu_rd || ifetch;
        grant_any = cpu_any || dma_req;
        owner_d   = OWN_IF;
        we_d      = 1'b0;
        io_d      = 1'b0;
        addr_d    = addr;
        wdata_d   = wdata;
        wmask_d   = '0;
        rstrobe_d = 2'b00;
        starve_d  = starve_q;
        if (dma_req && (!cpu_any || starve_q == STARVE_W)) begin
            owner_d   = OWN_DMA;
            we_d      = dma_we;
            addr_d    = dma_addr;
            wdata_d   = dma_wdata;
            wmask_d   = {MW{dma_we}};
            rstrobe_d = {2{~dma_we}};
            starve_d  = '0;
        end else begin
            if (cpu_wr) begin
                owner_d = OWN_WR;
                we_d    = 1'b1;
                wmask_d = wmask;
            end else if (cpu_rd) begin
                owner_d   = OWN_RD;
                rstrobe_d = rstrobe;
            end else begin
                owner_d   = OWN_IF;
                rstrobe_d = 2'b11;
            end
            io_d = io_access;
            // A CPU win while DMA waits counts as a lost arbitration for DMA
            if (dma_req && starve_q < STARVE_W) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // IDLE -> BUSY on a grant, BUSY -> DONE on ack, DONE -> IDLE after the one-cycle done pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_IF;
            starve_q      <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_io_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            mem_rstrobe_q <= 2'b00;
            rdata_q       <= '0;
            idone_q       <= 1'b0;
            rdone_q       <= 1'b0;
            wdone_q       <= 1'b0;
            dma_done_q    <= 1'b0;
        end else begin
            idone_q    <= 1'b0;
            rdone_q    <= 1'b0;
            wdone_q    <= 1'b0;
            dma_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        state_q       <= ST_BUSY;
                        owner_q       <= owner_d;
                        starve_q      <= starve_d;
                        mem_req_q     <= 1'b1;
                        mem_we_q      <= we_d;
                        mem_io_q      <= io_d;
                        mem_addr_q    <= addr_d;
                        mem_wdata_q   <= wdata_d;
                        mem_wmask_q   <= wmask_d;
                        mem_rstrobe_q <= rstrobe_d;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        state_q       <= ST_DONE;
                        rdata_q       <= mem_rdata;
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        mem_io_q      <= 1'b0;
                        mem_addr_q    <= '0;
                        mem_wdata_q   <= '0;
                        mem_wmask_q   <= '0;
                        mem_rstrobe_q <= 2'b00;
                        case (owner_q)
                            OWN_WR:  wdone_q    <= 1'b1;
                            OWN_RD:  rdone_q    <= 1'b1;
                            OWN_IF:  idone_q    <= 1'b1;
                            OWN_DMA: dma_done_q <= 1'b1;
                            default: idone_q    <= 1'b0;
                        endcase
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_io      = mem_io_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_rstrobe = mem_rstrobe_q;
    assign rdata       = rdata_q;
    assign idone       = idone_q;
    assign rdone       = rdone_q;
    assign wdone       = wdone_q;
    assign dma_done    = dma_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int RV = 32;
    localparam int VA = 32;
    localparam int AW = VA - RV / 16;
    localparam int MW = RV / 8;

    typedef struct packed {
        logic          we;
        logic          io;
        logic [AW-1:0] addr;
        logic [RV-1:0] wdata;
        logic [MW-1:0] wmask;
        logic [1:0]    rstrobe;
    } cmd_t;

    typedef struct packed {
        logic [1:0]    kind;
        logic [RV-1:0] rdata;
    } done_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ifetch;
    logic [1:0]    rstrobe;
    logic [MW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [RV-1:0] wdata;
    logic          io_access;
    logic          idone, rdone, wdone, dma_done;
    logic [RV-1:0] rdata;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [RV-1:0] dma_wdata;
    logic          mem_req, mem_we, mem_io;
    logic [AW-1:0] mem_addr;
    logic [RV-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic [1:0]    mem_rstrobe;
    logic          mem_ack;
    logic [RV-1:0] mem_rdata;

    logic          resp_ack  = 1'b0;
    logic          stray_ack = 1'b0;
    logic          use_fix   = 1'b0;
    logic [RV-1:0] fix_rdata = '0;
    int            ack_wait  = 0;
    int            wait_cnt  = 0;

    int            n_vec = 0;
    int            n_err = 0;
    cmd_t          exp_cmd[$];
    done_t         exp_done[$];
    logic [RV-1:0] last_rdata = '0;
    cmd_t          prev_cmd;
    logic          prev_req = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [RV-1:0] mem_fn(input logic [AW-1:0] a);
        return {2'b00, a} ^ 32'h5A5A_0000;
    endfunction

    assign mem_ack   = resp_ack | stray_ack;
    assign mem_rdata = use_fix ? fix_rdata : mem_fn(mem_addr);

    mem_arbiter #(.RV(RV), .VA(VA), .STARVE(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .ifetch(ifetch), .rstrobe(rstrobe), .wmask(wmask), .addr(addr),
        .wdata(wdata), .io_access(io_access),
        .idone(idone), .rdone(rdone), .wdone(wdone), .rdata(rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_done(dma_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrobe(mem_rstrobe), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    function automatic cmd_t mk_cmd(input logic we, input logic io, input logic [AW-1:0] a,
                                    input logic [RV-1:0] wd, input logic [MW-1:0] wm,
                                    input logic [1:0] rs);
        cmd_t c;
        c.we = we; c.io = io; c.addr = a; c.wdata = wd; c.wmask = wm; c.rstrobe = rs;
        return c;
    endfunction

    task automatic expect_txn(input cmd_t c, input logic [1:0] kind, input logic [RV-1:0] rd);
        done_t d;
        d.kind  = kind;
        d.rdata = rd;
        exp_cmd.push_back(c);
        exp_done.push_back(d);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_done(input int kind);
        int n;
        logic [3:0] dv;
        n = 0;
        dv = '0;
        while (n < 60) begin
            @(negedge clk);
            dv = {dma_done, idone, rdone, wdone};
            if (dv[kind]) break;
            n++;
        end
        if (n >= 60) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_done_%0d: got no pulse, required pulse", kind);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected commands/dones, checks stability and idle outputs, then plays the memory
    initial begin
        forever begin
            cmd_t       cur;
            cmd_t       ec;
            done_t      ed;
            logic [3:0] dv;
            @(negedge clk);
            cur = {mem_we, mem_io, mem_addr, mem_wdata, mem_wmask, mem_rstrobe};
            dv  = {dma_done, idone, rdone, wdone};
            if (reset_n) begin
                n_vec++;
                if (dv != 4'b0000) begin
                    if (exp_done.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_done: got %b, required 0000", dv);
                    end else begin
                        ed = exp_done.pop_front();
                        last_rdata = ed.rdata;
                        if (dv != (4'b0001 << ed.kind) || rdata !== ed.rdata) begin
                            n_err++;
                            $display("FAIL done_pulse: got dones %b rdata %h, required dones %b rdata %h",
                                     dv, rdata, 4'b0001 << ed.kind, ed.rdata);
                        end
                    end
                end else if (rdata !== last_rdata) begin
                    n_err++;
                    $display("FAIL rdata_hold: got %h, required %h", rdata, last_rdata);
                end
                if (mem_req && !prev_req) begin
                    n_vec++;
                    if (exp_cmd.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_req: got cmd %h, required no request", cur);
                    end else begin
                        ec = exp_cmd.pop_front();
                        if (cur !== ec) begin
                            n_err++;
                            $display("FAIL mem_cmd: got %h, required %h", cur, ec);
                        end
                    end
                end else if (mem_req && prev_req) begin
                    n_vec++;
                    if (cur !== prev_cmd) begin
                        n_err++;
                        $display("FAIL busy_stable: got %h, required %h", cur, prev_cmd);
                    end
                end
                if (!mem_req && wmask == '0 && rstrobe == 2'b00 && !ifetch && !dma_req) begin
                    n_vec++;
                    if (cur !== '0) begin
                        n_err++;
                        $display("FAIL idle_cmd_zero: got %h, required 0", cur);
                    end
                end
            end
            prev_req = mem_req;
            prev_cmd = cur;
            if (mem_req && !resp_ack) begin
                if (wait_cnt >= ack_wait) resp_ack = 1'b1;
                else wait_cnt++;
            end else begin
                resp_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int cnt;
        int guard;
        reset_n = 1'b0; ifetch = 1'b0; rstrobe = 2'b00; wmask = '0; addr = '0;
        wdata = '0; io_access = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_req_done", {mem_req, idone, rdone, wdone, dma_done}, 64'h0);
        check("reset_cmd", {mem_we, mem_io, mem_wmask, mem_rstrobe}, 64'h0);
        check("reset_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        check("reset_rdata", rdata, 64'h0);

        // Fetch with the minimum latency profile
        @(posedge clk); #1;
        use_fix = 1'b1; fix_rdata = 32'h1234_ABCD; addr = 30'h10; ifetch = 1'b1;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h10, '0, '0, 2'b11), 2'd2, 32'h1234_ABCD);
        @(negedge clk);
        check("lat_c0_req", mem_req, 64'h0);
        @(negedge clk);
        check("lat_c1_req_strobe", {mem_req, mem_rstrobe}, 64'h7);
        @(negedge clk);
        check("lat_c2_idone", {idone, rdata}, {31'h0, 1'b1, 32'h1234_ABCD});
        @(posedge clk); #1;
        ifetch = 1'b0;
        @(negedge clk);
        check("lat_c3_no_req", mem_req, 64'h0);
        @(negedge clk);
        check("lat_c4_no_req", mem_req, 64'h0);
        use_fix = 1'b0;

        // Write and fetch together: write first, fetch only after re-sampling in IDLE
        @(posedge clk); #1;
        addr = 30'h20; wdata = 32'hDEAD_BEEF; wmask = 4'b0100; ifetch = 1'b1;
        expect_txn(mk_cmd(1'b1, 1'b0, 30'h20, 32'hDEAD_BEEF, 4'b0100, 2'b00), 2'd0, mem_fn(30'h20));
        wait_done(0);
        wmask = '0; addr = 30'h24; wdata = '0;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h24, '0, '0, 2'b11), 2'd2, mem_fn(30'h24));
        @(negedge clk);
        check("fetch_after_write_c3", mem_req, 64'h0);
        wait_done(2);
        ifetch = 1'b0;

        // IO read with partial strobe and a delayed ack
        ack_wait = 2;
        rstrobe = 2'b01; io_access = 1'b1; addr = 30'h44;
        expect_txn(mk_cmd(1'b0, 1'b1, 30'h44, '0, '0, 2'b01), 2'd1, mem_fn(30'h44));
        wait_done(1);
        rstrobe = 2'b00; io_access = 1'b0; ack_wait = 0;

        // Write and read together: write first, then the read
        wmask = 4'b1111; rstrobe = 2'b10; addr = 30'h80; wdata = 32'h0BAD_F00D;
        expect_txn(mk_cmd(1'b1, 1'b0, 30'h80, 32'h0BAD_F00D, 4'b1111, 2'b00), 2'd0, mem_fn(30'h80));
        wait_done(0);
        wmask = '0;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h80, 32'h0BAD_F00D, '0, 2'b10), 2'd1, mem_fn(30'h80));
        wait_done(1);
        rstrobe = 2'b00; wdata = '0;

        // Stray ack while idle must be ignored
        @(posedge clk); #1;
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ack_no_done", {idone, rdone, wdone, dma_done, rdata},
                  {4'b0000, mem_fn(30'h80)});
        end
        @(posedge clk); #1;
        stray_ack = 1'b0;

        // Starvation: two CPU wins, then DMA; counter cleared so two more CPU wins before DMA again
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 30'h300; dma_wdata = '0;
        ifetch = 1'b1; addr = 30'h100;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h100, '0, '0, 2'b11), 2'd2, mem_fn(30'h100));
        wait_done(2);
        addr = 30'h104;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h104, '0, '0, 2'b11), 2'd2, mem_fn(30'h104));
        wait_done(2);
        addr = 30'h108;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h300, '0, '0, 2'b11), 2'd3, mem_fn(30'h300));
        wait_done(3);
        dma_req = 1'b0;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h108, '0, '0, 2'b11), 2'd2, mem_fn(30'h108));
        wait_done(2);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 30'h304; dma_wdata = 32'h55AA_55AA;
        addr = 30'h10C;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h10C, '0, '0, 2'b11), 2'd2, mem_fn(30'h10C));
        wait_done(2);
        addr = 30'h110;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h110, '0, '0, 2'b11), 2'd2, mem_fn(30'h110));
        wait_done(2);
        expect_txn(mk_cmd(1'b1, 1'b0, 30'h304, 32'h55AA_55AA, 4'b1111, 2'b00), 2'd3, mem_fn(30'h304));
        wait_done(3);
        dma_req = 1'b0; dma_we = 1'b0; dma_wdata = '0; ifetch = 1'b0;

        // DMA read with ack held off for five cycles
        @(posedge clk); #1;
        ack_wait = 5;
        dma_req = 1'b1; dma_addr = 30'h1A0;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h1A0, '0, '0, 2'b11), 2'd3, mem_fn(30'h1A0));
        guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (!mem_req && guard < 20);
        cnt = 0;
        while (mem_req && !mem_ack && guard < 40) begin
            cnt++;
            guard++;
            @(negedge clk); #1;
        end
        check("dma_wait_cycles", cnt, 64'd5);
        wait_done(3);
        dma_req = 1'b0; ack_wait = 0;

        // Reset during BUSY, then a late ack
        ack_wait = 100;
        rstrobe = 2'b11; addr = 30'h200;
        exp_cmd.push_back(mk_cmd(1'b0, 1'b0, 30'h200, '0, '0, 2'b11));
        @(negedge clk);
        @(negedge clk);
        check("busy_before_reset", mem_req, 64'h1);
        @(posedge clk); #1;
        reset_n = 1'b0; rstrobe = 2'b00;
        @(posedge clk); #1;
        reset_n = 1'b1; last_rdata = '0; stray_ack = 1'b1;
        @(negedge clk);
        check("after_reset_req_rdata", {mem_req, rdata}, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        stray_ack = 1'b0; ack_wait = 0;
        repeat (4) @(posedge clk);
        #1;

        // Back in IDLE: a fresh read is served normally
        rstrobe = 2'b11; addr = 30'h2A0;
        expect_txn(mk_cmd(1'b0, 1'b0, 30'h2A0, '0, '0, 2'b11), 2'd1, mem_fn(30'h2A0));
        wait_done(1);
        rstrobe = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        check("queues_drained", {exp_cmd.size(), exp_done.size()}, 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
